// File: rtl/ov5640_capture.sv
// OV5640 DVP capture: resynchronises the camera bus into sysclk, skips startup frames, assembles RGB565 pixels.
// Latency: pix_valid rises 4 sysclk cycles after the sysclk-aligned cmos_pclk edge carrying the low byte.
// No backpressure: the camera cannot be stalled, so pixels are strobed out and must be consumed on pix_valid.
module ov5640_capture #(
  parameter int FRAME_SKIP = 10,
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        cfg_done,
  input  logic        cmos_pclk,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_err,
  output logic [7:0]  frame_cnt
);

  localparam logic [7:0]  SKIP_N = 8'(FRAME_SKIP);
  localparam logic [11:0] H_LIM  = 12'(H_ACT);
  localparam logic [11:0] V_LIM  = 12'(V_ACT);

  typedef enum logic [1:0] {IDLE, SKIP, WAIT_VS, CAPTURE} state_t;

  // Index 0 is the first synchroniser flop, 1 the second, 2 the edge-detect history.
  logic [2:0] pclk_sync;
  logic [2:0] vsync_sync;
  logic [2:0] href_sync;
  logic [7:0] data_s1;
  logic [7:0] data_s2;

  logic pclk_rise;
  logic vs_rise;
  logic vs_fall;
  logic href_fall;

  state_t      state;
  logic [7:0]  skip_cnt;
  logic [11:0] col;
  logic [11:0] row;
  logic        phase;
  logic [7:0]  hi_byte;

  // Pixel assembled on the pclk edge; held one cycle before being presented.
  logic        pair_vld;
  logic [15:0] pair_dat;
  logic [11:0] pair_x;
  logic [11:0] pair_y;

  assign pclk_rise = pclk_sync[1] & ~pclk_sync[2];
  assign vs_rise   = vsync_sync[1] & ~vsync_sync[2];
  assign vs_fall   = ~vsync_sync[1] & vsync_sync[2];
  assign href_fall = ~href_sync[1] & href_sync[2];

  // Two-flop synchronisers for the camera bus plus one history flop for edge detection.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      pclk_sync  <= '0;
      vsync_sync <= '0;
      href_sync  <= '0;
      data_s1    <= '0;
      data_s2    <= '0;
    end else begin
      pclk_sync  <= {pclk_sync[1:0], cmos_pclk};
      vsync_sync <= {vsync_sync[1:0], cmos_vsync};
      href_sync  <= {href_sync[1:0], cmos_href};
      data_s1    <= cmos_data;
      data_s2    <= data_s1;
    end
  end

  // Frame-skip / capture FSM with byte pairing, line/frame bookkeeping and registered outputs.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      skip_cnt    <= '0;
      col         <= '0;
      row         <= '0;
      phase       <= 1'b0;
      hi_byte     <= '0;
      pair_vld    <= 1'b0;
      pair_dat    <= '0;
      pair_x      <= '0;
      pair_y      <= '0;
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_err    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      pair_vld    <= 1'b0;
      pix_valid   <= pair_vld;
      if (pair_vld) begin
        pix_data <= pair_dat;
        pix_x    <= pair_x;
        pix_y    <= pair_y;
      end
      if (!cfg_done) begin
        // Losing configuration abandons the frame silently: no frame_end.
        state     <= IDLE;
        skip_cnt  <= '0;
        phase     <= 1'b0;
        pix_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            skip_cnt <= '0;
            state    <= (SKIP_N == 8'd0) ? WAIT_VS : SKIP;
          end
          SKIP: begin
            if (vs_rise) begin
              skip_cnt <= skip_cnt + 8'd1;
              if (skip_cnt + 8'd1 >= SKIP_N) state <= WAIT_VS;
            end
          end
          WAIT_VS: begin
            if (vs_fall) begin
              state       <= CAPTURE;
              frame_start <= 1'b1;
              col         <= '0;
              row         <= '0;
              phase       <= 1'b0;
              pix_x       <= '0;
              pix_y       <= '0;
            end
          end
          CAPTURE: begin
            if (vs_rise) begin
              // A partial line in flight is dropped with the frame.
              state     <= WAIT_VS;
              frame_end <= 1'b1;
              frame_cnt <= frame_cnt + 8'd1;
              col       <= '0;
              phase     <= 1'b0;
            end else if (href_fall) begin
              col   <= '0;
              phase <= 1'b0;
              if (phase) line_err <= 1'b1;
              if (col != 12'd0 && row < V_LIM) row <= row + 12'd1;
            end else if (pclk_rise && href_sync[1]) begin
              if (!phase) begin
                hi_byte <= data_s2;
                phase   <= 1'b1;
              end else begin
                phase <= 1'b0;
                if (col < H_LIM) begin
                  col <= col + 12'd1;
                  if (row < V_LIM) begin
                    pair_vld <= 1'b1;
                    pair_dat <= {hi_byte, data_s2};
                    pair_x   <= col;
                    pair_y   <= row;
                  end
                end else begin
                  // Column counter sits at H_ACT; extra pixels only flag the overrun.
                  line_err <= 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov5640_capture.sv
// Directed bench for ov5640_capture with FRAME_SKIP=2, H_ACT=4, V_ACT=2 and pclk = sysclk/4.
// Stimulus tasks push expected pixels into a queue; a negedge monitor pops and compares.
// Covers reset values, frame skipping, odd/overlong lines, mid-line vsync, cfg_done drop and mid-frame reset.
module tb_ov5640_capture;

  localparam int H = 4;
  localparam int V = 2;

  logic        sysclk = 1'b0;
  logic        rst;
  logic        cfg_done;
  logic        cmos_pclk;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        frame_start;
  logic        frame_end;
  logic        line_err;
  logic [7:0]  frame_cnt;

  ov5640_capture #(.FRAME_SKIP(2), .H_ACT(H), .V_ACT(V)) dut (
    .sysclk(sysclk), .rst(rst), .cfg_done(cfg_done),
    .cmos_pclk(cmos_pclk), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .frame_end(frame_end), .line_err(line_err), .frame_cnt(frame_cnt)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
    int          t;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  int          pv_cnt = 0;
  int          fs_cnt = 0;
  int          fe_cnt = 0;
  int          last_rise = 0;
  logic [15:0] first_pix = '0;
  bit          got_first = 1'b0;
  logic [7:0]  bval = 8'h12;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops one expectation per pix_valid and tracks frame pulses.
  always @(negedge sysclk) begin
    exp_t e;
    if (frame_start) fs_cnt++;
    if (frame_end) fe_cnt++;
    if (frame_start || frame_end) check("fs_fe_exclusive", 32'(frame_start & frame_end), 32'd0);
    if (pix_valid) begin
      pv_cnt++;
      if (!got_first) begin
        first_pix = pix_data;
        got_first = 1'b1;
      end
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pix: got data 0x%0h x %0d y %0d at cycle %0d, expected none",
                 pix_data, pix_x, pix_y, cyc);
      end else begin
        e = q.pop_front();
        check("pix_data", 32'(pix_data), 32'(e.d));
        check("pix_x", 32'(pix_x), e.x);
        check("pix_y", 32'(pix_y), e.y);
        check("pix_latency_cycle", cyc, e.t);
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cmos_pclk = 1'b0;
    cmos_href = 1'b1;
    cmos_data = b;
    tick();
    tick();
    cmos_pclk = 1'b1;
    last_rise = cyc;
    tick();
    tick();
  endtask

  task automatic idle_pclk(input int n);
    for (int i = 0; i < n; i++) begin
      cmos_pclk = 1'b0;
      cmos_href = 1'b0;
      cmos_data = 8'h00;
      tick();
      tick();
      cmos_pclk = 1'b1;
      tick();
      tick();
    end
  endtask

  task automatic send_line(input bit cap, input int y, input int nbytes, input bit close);
    logic [7:0] hi;
    hi = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      send_byte(bval);
      if (i % 2 == 0) hi = bval;
      else if (cap && (i / 2) < H && y < V) q.push_back('{d: {hi, bval}, x: i / 2, y: y, t: last_rise + 4});
      bval = bval + 8'h22;
    end
    if (close) idle_pclk(2);
  endtask

  task automatic vsync_pulse();
    idle_pclk(1);
    cmos_vsync = 1'b1;
    idle_pclk(3);
    cmos_vsync = 1'b0;
    idle_pclk(2);
  endtask

  task automatic send_frame(input bit cap, input int len0);
    bval = 8'h12;
    send_line(cap, 0, len0, 1'b1);
    send_line(cap, 1, 8, 1'b1);
    vsync_pulse();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    check({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    check({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_frame_end"}, 32'(frame_end), 32'd0);
    check({tag, "_line_err"}, 32'(line_err), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    int fe0;
    rst        = 1'b0;
    cfg_done   = 1'b0;
    cmos_pclk  = 1'b0;
    cmos_vsync = 1'b0;
    cmos_href  = 1'b0;
    cmos_data  = 8'h00;
    #2 rst = 1'b1;
    repeat (3) tick();
    check_reset_values("rst");
    rst = 1'b0;
    tick();
    cfg_done = 1'b1;

    // Four frames: two skipped, two captured.
    send_frame(1'b0, 8);
    send_frame(1'b0, 8);
    send_frame(1'b1, 8);
    send_frame(1'b1, 8);
    repeat (4) tick();
    check("s1_frame_cnt", 32'(frame_cnt), 32'd2);
    check("s1_pix_count", pv_cnt, 32'd16);
    check("s1_first_pix", 32'(first_pix), 32'h1234);
    check("s1_frame_end_cnt", fe_cnt, 32'd2);
    check("s1_frame_start_cnt", fs_cnt, 32'd3);
    check("s1_line_err", 32'(line_err), 32'd0);

    // Odd-length line: 4 pixels, orphan dropped, next line still row 1.
    send_frame(1'b1, 9);
    repeat (4) tick();
    check("s2_line_err", 32'(line_err), 32'd1);
    check("s2_frame_cnt", 32'(frame_cnt), 32'd3);

    // Reset mid-frame, then full skip before capture resumes.
    bval = 8'h12;
    send_line(1'b1, 0, 4, 1'b0);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    check_reset_values("midrst");
    tick();
    rst = 1'b0;
    idle_pclk(2);
    vsync_pulse();
    send_frame(1'b0, 8);
    send_frame(1'b1, 8);
    repeat (4) tick();
    check("s3_frame_cnt", 32'(frame_cnt), 32'd1);

    // vsync rising mid-line: frame_end, half pixel dropped, next frame from (0,0).
    fe0 = fe_cnt;
    bval = 8'h12;
    send_line(1'b1, 0, 8, 1'b1);
    send_line(1'b1, 1, 3, 1'b0);
    cmos_vsync = 1'b1;
    repeat (8) tick();
    idle_pclk(2);
    cmos_vsync = 1'b0;
    idle_pclk(2);
    send_frame(1'b1, 8);
    repeat (4) tick();
    check("s4_frame_end_delta", fe_cnt - fe0, 32'd2);
    check("s4_line_err", 32'(line_err), 32'd0);
    check("s4_frame_cnt", 32'(frame_cnt), 32'd3);

    // Overlong line: 6 pixels offered, only 4 emitted.
    send_frame(1'b1, 12);
    repeat (4) tick();
    check("s5_line_err", 32'(line_err), 32'd1);
    check("s5_frame_cnt", 32'(frame_cnt), 32'd4);

    // cfg_done dropped mid-capture: output stops, no frame_end, skip repeats.
    fe0 = fe_cnt;
    bval = 8'h12;
    send_line(1'b1, 0, 4, 1'b0);
    repeat (8) tick();
    cfg_done = 1'b0;
    tick();
    check("s6_pix_valid_after_drop", 32'(pix_valid), 32'd0);
    tick();
    send_line(1'b0, 0, 4, 1'b1);
    send_line(1'b0, 1, 8, 1'b1);
    vsync_pulse();
    check("s6_no_frame_end", fe_cnt - fe0, 32'd0);
    cfg_done = 1'b1;
    send_frame(1'b0, 8);
    send_frame(1'b0, 8);
    send_frame(1'b1, 8);
    repeat (8) tick();
    check("s6_frame_end_delta", fe_cnt - fe0, 32'd1);
    check("s6_frame_cnt", 32'(frame_cnt), 32'd5);

    repeat (20) tick();
    check("pending_expected", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
